// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router ingress controller
package router_pkg;
  localparam int BYTE_W = 8;
  localparam int LEN_W = 6;
  localparam logic [1:0] ADDR_DROP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EMPTY,
    S_LFD,
    S_HDR_WR,
    S_LOAD_DATA,
    S_CHECK,
    S_DROP
  } state_e;
endpackage

// File: rtl/router_parity_reg.sv
// rtl/router_parity_reg.sv - header, parity accumulator, received parity and payload counter
// ROUTER_LEN_CHECK_EN adds the payload counter and its compare against header[7:2].
module router_parity_reg
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hdr_load,
  input  logic              i_acc,
  input  logic              i_rx_load,
  input  logic [BYTE_W-1:0] i_data,
  output logic [BYTE_W-1:0] o_header,
  output logic [BYTE_W-1:0] o_parity,
  output logic [BYTE_W-1:0] o_rx_parity,
  output logic              o_len_err
);
  logic [BYTE_W-1:0] r_header;
  logic [BYTE_W-1:0] r_parity;
  logic [BYTE_W-1:0] r_rx_parity;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_header    <= '0;
      r_parity    <= '0;
      r_rx_parity <= '0;
    end else begin
      if (i_hdr_load) begin
        r_header <= i_data;
        r_parity <= i_data;
      end else if (i_acc) begin
        r_parity <= r_parity ^ i_data;
      end
      if (i_rx_load) r_rx_parity <= i_data;
    end
  end

`ifdef ROUTER_LEN_CHECK_EN
  logic [LEN_W-1:0] r_cnt;

  // Counts only payload bytes actually written; wraps at 64 like the length field.
  always_ff @(posedge clk) begin
    if (!rst)            r_cnt <= '0;
    else if (i_hdr_load) r_cnt <= '0;
    else if (i_acc)      r_cnt <= r_cnt + 1'b1;
  end

  assign o_len_err = (r_cnt != r_header[BYTE_W-1:BYTE_W-LEN_W]);
`else
  assign o_len_err = 1'b0;
`endif

  assign o_header    = r_header;
  assign o_parity    = r_parity;
  assign o_rx_parity = r_rx_parity;
endmodule

// File: rtl/router_ingress_ctrl.sv
// rtl/router_ingress_ctrl.sv - packet ingress FSM feeding three destination FIFOs
// ROUTER_LEN_CHECK_EN adds a payload-length check to the CHECK-state error.
module router_ingress_ctrl
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              pkt_valid,
  input  logic [2:0]        fifo_full,
  input  logic [2:0]        fifo_empty,
  input  logic [2:0]        soft_rst,
  output logic [BYTE_W-1:0] dout,
  output logic [2:0]        wr_en,
  output logic              lfd_state,
  output logic              busy,
  output logic              err,
  output logic              parity_done
);
  state_e            r_state;
  logic [BYTE_W-1:0] w_header;
  logic [BYTE_W-1:0] w_parity;
  logic [BYTE_W-1:0] w_rx_parity;
  logic              w_len_err;
  logic [1:0]        w_dest;
  logic [3:0]        w_full4, w_empty4, w_srst4;
  logic              w_sel_full, w_abort, w_load_wr;
  logic              w_hdr_load, w_acc, w_rx_load;
  logic [2:0]        w_onehot;

  // Padding to four entries makes dest=3 index a constant-zero slot.
  assign w_full4  = {1'b0, fifo_full};
  assign w_empty4 = {1'b0, fifo_empty};
  assign w_srst4  = {1'b0, soft_rst};

  assign w_dest     = (r_state == S_IDLE) ? data_in[1:0] : w_header[1:0];
  assign w_sel_full = w_full4[w_dest];
  assign w_abort    = w_srst4[w_dest] && (r_state != S_IDLE) && (r_state != S_DROP);
  assign w_load_wr  = (r_state == S_LOAD_DATA) && !w_sel_full && !w_abort;
  assign w_hdr_load = (r_state == S_IDLE) && pkt_valid;
  assign w_acc      = w_load_wr && pkt_valid;
  assign w_rx_load  = w_load_wr && !pkt_valid;
  assign w_onehot   = 3'(4'b0001 << w_dest);

  router_parity_reg u_parity_reg (
    .clk         (clk),
    .rst         (rst),
    .i_hdr_load  (w_hdr_load),
    .i_acc       (w_acc),
    .i_rx_load   (w_rx_load),
    .i_data      (data_in),
    .o_header    (w_header),
    .o_parity    (w_parity),
    .o_rx_parity (w_rx_parity),
    .o_len_err   (w_len_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (w_abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pkt_valid) begin
            if (data_in[1:0] == ADDR_DROP)  r_state <= S_DROP;
            else if (w_empty4[data_in[1:0]]) r_state <= S_LFD;
            else                             r_state <= S_WAIT_EMPTY;
          end
        end
        S_WAIT_EMPTY: if (w_empty4[w_dest]) r_state <= S_LFD;
        S_LFD:        r_state <= S_HDR_WR;
        S_HDR_WR:     r_state <= S_LOAD_DATA;
        S_LOAD_DATA:  if (w_rx_load) r_state <= S_CHECK;
        S_CHECK:      r_state <= S_IDLE;
        S_DROP:       if (!pkt_valid) r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end

  // Mealy outputs; held at zero while reset is asserted so a mid-packet reset stops writes at once.
  always_comb begin
    dout        = '0;
    wr_en       = '0;
    lfd_state   = 1'b0;
    busy        = 1'b0;
    err         = 1'b0;
    parity_done = 1'b0;
    if (rst) begin
      case (r_state)
        S_WAIT_EMPTY: busy = 1'b1;
        S_LFD: begin
          busy      = 1'b1;
          lfd_state = 1'b1;
        end
        S_HDR_WR: begin
          busy  = 1'b1;
          dout  = w_header;
          wr_en = w_abort ? 3'b000 : w_onehot;
        end
        S_LOAD_DATA: begin
          busy  = w_sel_full;
          dout  = data_in;
          wr_en = w_load_wr ? w_onehot : 3'b000;
        end
        S_CHECK: begin
          busy        = 1'b1;
          parity_done = !w_abort;
          err         = !w_abort && ((w_rx_parity != w_parity) || w_len_err);
        end
        S_DROP:  err = !pkt_valid;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_router_ingress_ctrl.sv
// tb/tb_router_ingress_ctrl.sv - scoreboard bench for router_ingress_ctrl
module tb_router_ingress_ctrl;
  typedef struct {
    logic [2:0] we;
    logic [7:0] d;
    logic       hdr;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic [2:0] fifo_full, fifo_empty, soft_rst;
  logic [7:0] dout;
  logic [2:0] wr_en;
  logic       lfd_state, busy, err, parity_done;

  wr_t        exp_wr[$];
  logic [1:0] exp_res[$];
  int         total = 0;
  int         bad = 0;
  bit         full_en = 1'b0;
  logic       lfd_prev = 1'b0;

  router_ingress_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .pkt_valid   (pkt_valid),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .soft_rst    (soft_rst),
    .dout        (dout),
    .wr_en       (wr_en),
    .lfd_state   (lfd_state),
    .busy        (busy),
    .err         (err),
    .parity_done (parity_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] dest);
    if (dest == 2'd0) return 3'b001;
    if (dest == 2'd1) return 3'b010;
    return 3'b100;
  endfunction

  // Random backpressure on the FIFO full flags.
  always @(posedge clk) begin
    #1;
    fifo_full <= full_en ? 3'($urandom_range(0, 7) & $urandom_range(0, 7)) : 3'b000;
  end

  // Monitor: every FIFO write and every result pulse is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t w;
    if (wr_en != 3'b000) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write", {21'd0, wr_en, dout}, 32'd0);
      end else begin
        w = exp_wr.pop_front();
        check("wr_en", {29'd0, wr_en}, {29'd0, w.we});
        check("dout", {24'd0, dout}, {24'd0, w.d});
        check("lfd_delayed", {31'd0, lfd_prev}, {31'd0, w.hdr});
        if (!w.hdr) check("write_while_full", {29'd0, wr_en & fifo_full}, 32'd0);
      end
    end
    if (err || parity_done) begin
      if (exp_res.size() == 0) check("unexpected_result", {30'd0, err, parity_done}, 32'd0);
      else check("err_pd", {30'd0, err, parity_done}, {30'd0, exp_res.pop_front()});
    end
    lfd_prev <= lfd_state;
  end

  // Presents one byte and holds it until a cycle with busy low; returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input logic v);
    int guard = 0;
    data_in   = b;
    pkt_valid = v;
    forever begin
      @(negedge clk);
      if (!busy) break;
      guard++;
      if (guard > 200) begin
        check("busy_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic [1:0] dest, input int len, input bit bad_par, input bit fixed);
    logic [7:0] hdr, b, par;
    hdr = {6'(len), dest};
    par = hdr;
    if (dest != 2'd3) exp_wr.push_back('{onehot(dest), hdr, 1'b1});
    send_byte(hdr, 1'b1);
    for (int i = 0; i < len; i++) begin
      b = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      par ^= b;
      if (dest != 2'd3) exp_wr.push_back('{onehot(dest), b, 1'b0});
      send_byte(b, 1'b1);
    end
    b = bad_par ? (par ^ 8'h5A) : par;
    if (dest != 2'd3) begin
      exp_wr.push_back('{onehot(dest), b, 1'b0});
      exp_res.push_back({bad_par, 1'b1});
    end else begin
      exp_res.push_back(2'b10);
    end
    send_byte(b, 1'b0);
  endtask

  initial begin
    logic [7:0] hdr, b, par;
    rst        = 1'b0;
    data_in    = 8'hA5;
    pkt_valid  = 1'b1;
    fifo_empty = 3'b111;
    soft_rst   = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_outs", {26'd0, wr_en, lfd_state, busy, err}, 32'd0);
    check("rst_pd", {31'd0, parity_done}, 32'd0);
    @(posedge clk); #1;
    rst       = 1'b1;
    pkt_valid = 1'b0;
    @(posedge clk); #1;

    send_pkt(2'd1, 3, 1'b0, 1'b1);
    send_pkt(2'd0, 4, 1'b1, 1'b0);
    send_pkt(2'd3, 3, 1'b0, 1'b0);

    // Destination FIFO 0 not empty for 5 cycles after the header is taken.
    fifo_empty = 3'b110;
    hdr = {6'd2, 2'd0};
    par = hdr;
    exp_wr.push_back('{3'b001, hdr, 1'b1});
    data_in   = hdr;
    pkt_valid = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    b = 8'h3C;
    data_in = b;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wait_empty_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    fifo_empty = 3'b111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("hdr_after_empty", {21'd0, wr_en, dout}, {21'd0, 3'b001, hdr});
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      b = 8'(8'h3C + i);
      par ^= b;
      exp_wr.push_back('{3'b001, b, 1'b0});
      send_byte(b, 1'b1);
    end
    exp_wr.push_back('{3'b001, par, 1'b0});
    exp_res.push_back(2'b01);
    send_byte(par, 1'b0);

    // Soft reset: bit 0 is ignored on a dest-1 packet, bit 1 aborts it.
    hdr = {6'd4, 2'd1};
    exp_wr.push_back('{3'b010, hdr, 1'b1});
    send_byte(hdr, 1'b1);
    soft_rst = 3'b001;
    exp_wr.push_back('{3'b010, 8'h77, 1'b0});
    send_byte(8'h77, 1'b1);
    soft_rst = 3'b010;
    data_in  = 8'h88;
    @(negedge clk);
    check("srst_wr_en", {29'd0, wr_en}, 32'd0);
    check("srst_err_pd", {30'd0, err, parity_done}, 32'd0);
    @(posedge clk); #1;
    soft_rst  = 3'b000;
    pkt_valid = 1'b0;
    @(negedge clk);
    check("srst_idle", {28'd0, busy, wr_en}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-packet to dest 2.
    hdr = {6'd5, 2'd2};
    exp_wr.push_back('{3'b100, hdr, 1'b1});
    send_byte(hdr, 1'b1);
    exp_wr.push_back('{3'b100, 8'h19, 1'b0});
    send_byte(8'h19, 1'b1);
    data_in = 8'h2A;
    rst     = 1'b0;
    @(negedge clk);
    check("midrst_outs", {20'd0, dout, wr_en, lfd_state}, 32'd0);
    check("midrst_flags", {29'd0, busy, err, parity_done}, 32'd0);
    @(posedge clk); #1;
    rst       = 1'b1;
    pkt_valid = 1'b0;
    @(negedge clk);
    check("postrst_idle", {28'd0, busy, wr_en}, 32'd0);
    @(posedge clk); #1;

    full_en = 1'b1;
    for (int n = 0; n < 30; n++)
      send_pkt(2'($urandom_range(0, 3)), $urandom_range(0, 6), ($urandom_range(0, 3) == 0), 1'b0);
    pkt_valid = 1'b0;
    full_en   = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("wr_queue_drained", exp_wr.size(), 32'd0);
    check("res_queue_drained", exp_res.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
